pc_gen_btb: RTL and testbench

//  Next-generation fetch PC generator. Replaces the fixed +4 sequencer with a parametrised XLEN unit.
//  Has a configurable reset vector and a direct-mapped branch target buffer (BTB) with 2-bit counters.

---
 rtl/pc_gen_btb.sv | 103 ++++++++++
 tb/tb_pc_gen_btb.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pc_gen_btb.sv
// Fetch PC generator with a configurable reset vector and a direct-mapped BTB.
// Each BTB entry has a 2-bit saturating counter; it is trained by resolved branches from execute.
module pc_gen_btb #(
    parameter int unsigned          XLEN         = 32,
    parameter logic [XLEN-1:0]      RESET_VECTOR = '0,
    parameter int unsigned          BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            flush,
    input  logic [XLEN-1:0] new_pc,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc_out,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic              btb_valid  [BTB_ENTRIES];
    logic [TAGW-1:0]   btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]   btb_target [BTB_ENTRIES];
    logic [1:0]        btb_ctr    [BTB_ENTRIES];

    logic [IDX-1:0]    look_idx;
    logic [TAGW-1:0]   look_tag;
    logic              look_hit;

    logic [IDX-1:0]    upd_idx;
    logic [TAGW-1:0]   upd_tag;
    logic              upd_hit;

    logic [XLEN-1:0]   pc_next;

    assign look_idx = pc_out[IDX+1:2];
    assign look_tag = pc_out[XLEN-1:IDX+2];
    assign upd_idx  = upd_pc[IDX+1:2];
    assign upd_tag  = upd_pc[XLEN-1:IDX+2];

    always_comb begin
        look_hit    = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
        pred_taken  = look_hit && btb_ctr[look_idx][1];
        pred_target = look_hit ? btb_target[look_idx] : '0;
    end

    always_comb begin
        upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);
    end

    // Redirect beats stall; stall beats prediction.
    always_comb begin
        pc_next = pc_out + XLEN'(4);
        if (flush) begin
            pc_next = new_pc;
        end else if (stall) begin
            pc_next = pc_out;
        end else if (pred_taken) begin
            pc_next = pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_out <= RESET_VECTOR;
        end else begin
            pc_out <= pc_next;
        end
    end

    // Training writes land at the edge, so a same-cycle lookup sees the old entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < BTB_ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= '0;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    btb_target[upd_idx] <= upd_target;
                    if (btb_ctr[upd_idx] != 2'b11) begin
                        btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
                    end
                end else if (btb_ctr[upd_idx] != 2'b00) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
                end
            end else if (upd_taken) begin
                btb_valid[upd_idx]  <= 1'b1;
                btb_tag[upd_idx]    <= upd_tag;
                btb_target[upd_idx] <= upd_target;
                btb_ctr[upd_idx]    <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen_btb.sv
// Directed bench for pc_gen_btb: sequencing, stall/flush, BTB training, aliasing, wrap and reset.
module tb_pc_gen_btb;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] pc_out;
    logic        pred_taken;
    logic [31:0] pred_target;

    int tests_run = 0;
    int tests_failed = 0;

    pc_gen_btb #(
        .XLEN        (32),
        .RESET_VECTOR(32'h0000_1000),
        .BTB_ENTRIES (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (flush),
        .new_pc     (new_pc),
        .upd_valid  (upd_valid),
        .upd_pc     (upd_pc),
        .upd_taken  (upd_taken),
        .upd_target (upd_target),
        .pc_out     (pc_out),
        .pred_taken (pred_taken),
        .pred_target(pred_target)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic redirect(input logic [31:0] addr);
        flush  = 1'b1;
        new_pc = addr;
        step();
        flush  = 1'b0;
    endtask

    task automatic train(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        step();
        upd_valid  = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; new_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;

        // 1: reset vector then sequential fetch
        step();
        check("rst_pc", pc_out, 32'h1000);
        check("rst_pt", 32'(pred_taken), 32'd0);
        check("rst_ptgt", pred_target, 32'd0);
        reset = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", pc_out, 32'h1000 + 32'(4 * i));
            check("seq_pt", 32'(pred_taken), 32'd0);
        end

        // 2: stall holds, flush overrides stall
        stall = 1'b1;
        step(); check("stall1", pc_out, 32'h1010);
        step(); check("stall2", pc_out, 32'h1010);
        redirect(32'h200);
        check("flush_stall", pc_out, 32'h200);
        stall = 1'b0;

        // 3: allocate 0x1008 -> 0x1400 alongside a redirect to 0x1000
        upd_valid = 1'b1; upd_pc = 32'h1008; upd_taken = 1'b1; upd_target = 32'h1400;
        redirect(32'h1000);
        upd_valid = 1'b0;
        check("s3_pc0", pc_out, 32'h1000);
        check("s3_pt0", 32'(pred_taken), 32'd0);
        step(); check("s3_pc1", pc_out, 32'h1004);
        step(); check("s3_pc2", pc_out, 32'h1008);
        check("s3_pt2", 32'(pred_taken), 32'd1);
        check("s3_tgt2", pred_target, 32'h1400);
        step(); check("s3_pc3", pc_out, 32'h1400);

        // 4: counter 2 -> 1 -> 0 -> 0 (floor), then taken 0 -> 1
        train(32'h1008, 1'b0, 32'h0);
        train(32'h1008, 1'b0, 32'h0);
        train(32'h1008, 1'b0, 32'h0);
        redirect(32'h1008);
        check("s4_pt_c0", 32'(pred_taken), 32'd0);
        check("s4_tgt_keep", pred_target, 32'h1400);
        step(); check("s4_seq", pc_out, 32'h100C);
        train(32'h1008, 1'b1, 32'h1400);
        redirect(32'h1008);
        check("s4_pt_c1", 32'(pred_taken), 32'd0);
        // 1 -> 2 -> 3 -> 3 (ceiling, new target), then not-taken -> 2
        train(32'h1008, 1'b1, 32'h1400);
        train(32'h1008, 1'b1, 32'h1400);
        train(32'h1008, 1'b1, 32'h1800);
        train(32'h1008, 1'b0, 32'h0);
        redirect(32'h1008);
        check("s4_pt_sat", 32'(pred_taken), 32'd1);
        check("s4_tgt_upd", pred_target, 32'h1800);
        // stall beats a prediction
        stall = 1'b1;
        step(); check("s4_stall_pred", pc_out, 32'h1008);
        stall = 1'b0;
        step(); check("s4_pred_pc", pc_out, 32'h1800);

        // 5: 0x1048 aliases idx 2 with a different tag and replaces 0x1008
        train(32'h1048, 1'b1, 32'h3000);
        redirect(32'h1008);
        check("s5_old_pt", 32'(pred_taken), 32'd0);
        check("s5_old_tgt", pred_target, 32'd0);
        step(); check("s5_old_pc", pc_out, 32'h100C);
        redirect(32'h1048);
        check("s5_new_pt", 32'(pred_taken), 32'd1);
        check("s5_new_tgt", pred_target, 32'h3000);
        // same-cycle training on the looked-up entry uses the old counter
        upd_valid = 1'b1; upd_pc = 32'h1048; upd_taken = 1'b0; upd_target = '0;
        step();
        upd_valid = 1'b0;
        check("s5_old_lookup", pc_out, 32'h3000);
        redirect(32'h1048);
        check("s5_new_contents", 32'(pred_taken), 32'd0);

        // 6: wrap-around and reset clearing the BTB
        redirect(32'hFFFF_FFFC);
        check("s6_wrap_pt", 32'(pred_taken), 32'd0);
        step(); check("s6_wrap_pc", pc_out, 32'h0);
        train(32'h1008, 1'b1, 32'h1400);
        redirect(32'h1008);
        check("s6_pre_rst_pt", 32'(pred_taken), 32'd1);
        reset = 1'b1;
        upd_valid = 1'b1; upd_pc = 32'h1048; upd_taken = 1'b1; upd_target = 32'h3000;
        step();
        reset = 1'b0; upd_valid = 1'b0;
        check("s6_rst_pc", pc_out, 32'h1000);
        redirect(32'h1008);
        check("s6_post_pt", 32'(pred_taken), 32'd0);
        check("s6_post_tgt", pred_target, 32'd0);
        step(); check("s6_post_pc", pc_out, 32'h100C);
        redirect(32'h1048);
        check("s6_rst_upd_ignored", 32'(pred_taken), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
